mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: the CPU (controller-driven fetch/load/store/const) and the IO/DMA engine.
- Grants one requester at a time. Holds the grant until the memory acknowledges, or until a watchdog expires.
- Sits between the CPU datapath/controller and the memory/bus interface.
- Default policy is fixed priority with the CPU first; an optional macro selects round-robin.

Parameters:
- AW, 16, address width in bits.
- DW, 16, data word width in bits.
- TIMEOUT, 15, cycles a grant may wait for mem_ack before forced release (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- cpu_read  in  1  CPU read request, level, held until cpu_ack.
- cpu_write  in  1  CPU write request, level, held until cpu_ack.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  CPU transfer complete, one-cycle pulse.
- io_read  in  1  IO read request, level, held until io_ack.
- io_write  in  1  IO write request, level, held until io_ack.
- io_addr  in  AW  IO address.
- io_wdata  in  DW  IO write data.
- io_ack  out  1  IO transfer complete, one-cycle pulse.
- rdata  out  DW  memory read data, passed to both requesters.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- rdata_mem  in  DW  memory read data.
- timeout_err  out  1  one-cycle pulse when a grant is force-released.
- grant_out  out  2  visualization: 0 IDLE, 1 CPU, 2 IO.

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0, last-served=IO, timeout_err=0. All mem_*, *_ack = 0. Address/data outputs = 0.
- Registered state: IDLE, GRANT_CPU, GRANT_IO. grant_out encodes the state.
- A requester is "pending" when its read or write request is high. Read and write high together on one requester is illegal; in that case read wins.
- IDLE, one requester pending: go to GRANT of that requester on the next edge.
- IDLE, both pending: GRANT_CPU (fixed priority).
- Arbitration latency: request seen at edge N, memory strobe asserted during cycle N+1.
- GRANT_x, memory side (combinational from state): mem_read = x_read, mem_write = x_write & ~x_read, mem_addr = x_addr, mem_wdata = x_wdata. A strobe therefore drops if the requester withdraws.
- GRANT_x, acknowledge: x_ack = mem_ack (combinational). The other requester's ack is 0.
- GRANT_x, on mem_ack: clear the wait counter and record last-served = x.
  - Other requester pending: go directly to GRANT_other (back-to-back, no idle cycle).
  - Otherwise: go to IDLE.
- GRANT_x, no mem_ack: increment the wait counter (8-bit, saturating). When the counter equals TIMEOUT-1 and mem_ack=0: timeout_err=1 for that cycle, x_ack stays 0, go to IDLE, clear the counter. The requester keeps requesting and re-arbitrates.
- GRANT_x, requester drops its request without mem_ack: return to IDLE next edge, counter cleared, no ack.
- rdata = rdata_mem always (unregistered). Requesters sample it with their ack.
- IDLE: all mem strobes 0, mem_addr/mem_wdata = 0.
- mem_ack while IDLE is ignored; no ack is generated.
- Reset mid-transfer: strobes drop immediately. The transfer is abandoned and the ack is never generated.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: when both requesters are pending in IDLE, or back-to-back after mem_ack, grant the requester that is not last-served (round-robin).
- Undefined: CPU always wins on a tie. last-served is still maintained but does not affect arbitration.

Test Plan:
- CPU read only: cpu_read=1, cpu_addr=0x0010, mem_ack one cycle after mem_read rises, rdata_mem=0xBEEF.
  - Required: mem_read rises 1 cycle after the request, mem_addr=0x0010, cpu_ack pulses with rdata=0xBEEF, state then IDLE.
- Simultaneous requests: cpu_read@0x0001 and io_write@0x0200 (data 0x1234) in the same cycle, each acked after 2 cycles.
  - Required: CPU served first, then IO back-to-back with mem_write=1, mem_addr=0x0200, mem_wdata=0x1234, no IDLE gap.
  - With MEM_ARB_RR_EN and last-served=CPU: IO is served first.
- Timeout: io_read held, mem_ack never asserted, TIMEOUT=15.
  - Required: timeout_err pulses exactly once, 15 cycles after grant. io_ack=0. Re-grant to IO on the following edge.
- Withdrawal: CPU grant begins, cpu_read drops after 2 cycles.
  - Required: mem_read falls the same cycle, IDLE next edge, no cpu_ack, no timeout_err.
- Reset mid-transfer: assert reset during GRANT_IO with mem_write=1.
  - Required: mem_write=0 and grant_out=0 immediately (async). After release, the first request is arbitrated from IDLE.
- Stray ack: mem_ack pulsed while IDLE.
  - Required: cpu_ack=io_ack=0, state unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, IO) arbiter for a single memory port, with a per-grant ack watchdog.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU wins every tie.
module mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          io_read,
  input  logic          io_write,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_wdata,
  output logic          io_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] rdata_mem,
  output logic          timeout_err,
  output logic [1:0]    grant_out
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CPU  = 2'd1;
  localparam logic [1:0] ST_IO   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          last_io_q, last_io_d;

  logic          cpu_pend, io_pend, tie_io;
  logic          g_io, g_read, g_write, g_pend, o_pend;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;

  assign cpu_pend  = cpu_read | cpu_write;
  assign io_pend   = io_read | io_write;
  assign rdata     = rdata_mem;
  assign grant_out = state_q;

  // Tie-break between simultaneous requesters
`ifdef MEM_ARB_RR_EN
  assign tie_io = ~last_io_q;
`else
  assign tie_io = 1'b0;
`endif

  // Request lines of the currently granted requester and pending status of the other
  always_comb begin
    g_io    = (state_q == ST_IO);
    g_read  = g_io ? io_read   : cpu_read;
    g_write = g_io ? io_write  : cpu_write;
    g_addr  = g_io ? io_addr   : cpu_addr;
    g_wdata = g_io ? io_wdata  : cpu_wdata;
    g_pend  = g_read | g_write;
    o_pend  = g_io ? cpu_pend  : io_pend;
  end

  // Next-state, watchdog and memory-side outputs
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    last_io_d   = last_io_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_ack     = 1'b0;
    io_ack      = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (cpu_pend && io_pend) state_d = tie_io ? ST_IO : ST_CPU;
        else if (cpu_pend)       state_d = ST_CPU;
        else if (io_pend)        state_d = ST_IO;
      end
      ST_CPU, ST_IO: begin
        // Read wins if a requester illegally raises both strobes
        mem_read  = g_read;
        mem_write = g_write & ~g_read;
        mem_addr  = g_addr;
        mem_wdata = g_wdata;
        cpu_ack   = mem_ack & ~g_io;
        io_ack    = mem_ack & g_io;
        if (mem_ack) begin
          wait_d    = '0;
          last_io_d = g_io;
          if (o_pend) state_d = g_io ? ST_CPU : ST_IO;
          else        state_d = ST_IDLE;
        end else if (!g_pend) begin
          wait_d  = '0;
          state_d = ST_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_err = 1'b1;
          wait_d      = '0;
          state_d     = ST_IDLE;
        end else if (wait_q != '1) begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      last_io_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      last_io_q <= last_io_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: directed scenarios, then randomized CPU/IO traffic
// against a memory whose read data is a fixed function of the address.
module tb_mem_arbiter;

  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 16;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [DW-1:0] RD_KEY = 16'hBEFF;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_read, cpu_write, io_read, io_write;
  logic [AW-1:0] cpu_addr, io_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, io_wdata, mem_wdata, rdata, rdata_mem;
  logic          cpu_ack, io_ack, mem_read, mem_write, mem_ack, timeout_err;
  logic [1:0]    grant_out;

  logic          agent_en, agent_ack, dir_ack;
  int            a_cnt, a_dly;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            to_cnt  = 0;
  txn_t          cpu_q[$];
  txn_t          io_q[$];

  always #5 clock = ~clock;

  // Memory model: read data is the address scrambled with a fixed key
  assign rdata_mem = mem_addr ^ RD_KEY;
  assign mem_ack   = agent_en ? agent_ack : dir_ack;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .io_read(io_read), .io_write(io_write), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .rdata_mem(rdata_mem),
    .timeout_err(timeout_err), .grant_out(grant_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Random-latency memory responder: acks 0..3 cycles into each strobed transfer
  always @(posedge clock) begin
    #2;
    if (agent_en && (mem_read || mem_write)) begin
      if (a_cnt >= a_dly) begin
        agent_ack = 1'b1;
        a_cnt     = 0;
        a_dly     = $urandom_range(0, 3);
      end else begin
        agent_ack = 1'b0;
        a_cnt++;
      end
    end else begin
      agent_ack = 1'b0;
      a_cnt     = 0;
    end
  end

  // Monitor: every ack retires the oldest expected transfer of that requester
  always @(negedge clock) begin
    txn_t t;
    if (cpu_ack) begin
      if (cpu_q.size() == 0) check("cpu_ack_unexpected", 32'(cpu_ack), 32'(0));
      else begin
        t = cpu_q.pop_front();
        check("cpu_grant", 32'(grant_out), 32'(1));
        check("cpu_addr", 32'(mem_addr), 32'(t.addr));
        check("cpu_dir", 32'({mem_read, mem_write}), 32'({~t.wr, t.wr}));
        if (t.wr) check("cpu_wdata", 32'(mem_wdata), 32'(t.wdata));
        else      check("cpu_rdata", 32'(rdata), 32'(t.addr ^ RD_KEY));
      end
    end
    if (io_ack) begin
      if (io_q.size() == 0) check("io_ack_unexpected", 32'(io_ack), 32'(0));
      else begin
        t = io_q.pop_front();
        check("io_grant", 32'(grant_out), 32'(2));
        check("io_addr", 32'(mem_addr), 32'(t.addr));
        check("io_dir", 32'({mem_read, mem_write}), 32'({~t.wr, t.wr}));
        if (t.wr) check("io_wdata", 32'(mem_wdata), 32'(t.wdata));
        else      check("io_rdata", 32'(rdata), 32'(t.addr ^ RD_KEY));
      end
    end
    if (timeout_err) to_cnt++;
  end

  // Both requesters raise together; the winner is served, then the other back-to-back
  task automatic both_test(input bit first_io);
    txn_t tc, ti;
    tc = '{wr: 1'b0, addr: 16'h0001, wdata: 16'h0000};
    ti = '{wr: 1'b1, addr: 16'h0200, wdata: 16'h1234};
    cyc();
    cpu_read = 1'b1; cpu_addr = tc.addr;
    io_write = 1'b1; io_addr = ti.addr; io_wdata = ti.wdata;
    cpu_q.push_back(tc); io_q.push_back(ti);
    @(negedge clock); check("both_idle", 32'(grant_out), 32'(0));
    cyc();
    @(negedge clock);
    check("both_first", 32'(grant_out), first_io ? 32'(2) : 32'(1));
    check("both_first_addr", 32'(mem_addr), first_io ? 32'(ti.addr) : 32'(tc.addr));
    cyc(); dir_ack = 1'b1;
    @(negedge clock);
    cyc(); dir_ack = 1'b0;
    if (first_io) io_write = 1'b0; else cpu_read = 1'b0;
    @(negedge clock);
    check("both_second", 32'(grant_out), first_io ? 32'(1) : 32'(2));
    check("both_second_addr", 32'(mem_addr), first_io ? 32'(tc.addr) : 32'(ti.addr));
    check("both_second_wr", 32'(mem_write), first_io ? 32'(0) : 32'(1));
    if (!first_io) check("both_io_wdata", 32'(mem_wdata), 32'(ti.wdata));
    cyc(); dir_ack = 1'b1;
    @(negedge clock);
    cyc(); dir_ack = 1'b0; cpu_read = 1'b0; io_write = 1'b0;
    @(negedge clock); check("both_done_idle", 32'(grant_out), 32'(0));
  endtask

  task automatic requester(input bit is_io, input int n);
    for (int i = 0; i < n; i++) begin
      txn_t t;
      int   w;
      repeat ($urandom_range(0, 3)) cyc();
      cyc();
      t.wr    = 1'($urandom_range(0, 1));
      t.addr  = AW'($urandom);
      t.wdata = DW'($urandom);
      if (is_io) begin
        io_read = ~t.wr; io_write = t.wr; io_addr = t.addr; io_wdata = t.wdata;
        io_q.push_back(t);
      end else begin
        cpu_read = ~t.wr; cpu_write = t.wr; cpu_addr = t.addr; cpu_wdata = t.wdata;
        cpu_q.push_back(t);
      end
      w = 0;
      do begin
        @(negedge clock);
        w++;
      end while (!(is_io ? io_ack : cpu_ack) && w < 200);
      check(is_io ? "io_ack_wait" : "cpu_ack_wait", 32'(is_io ? io_ack : cpu_ack), 32'(1));
      cyc();
      if (is_io) begin io_read = 1'b0; io_write = 1'b0; end
      else begin cpu_read = 1'b0; cpu_write = 1'b0; end
    end
  endtask

  initial begin
    int to0;
    reset = 1'b0; agent_en = 1'b0; agent_ack = 1'b0; dir_ack = 1'b0;
    a_cnt = 0; a_dly = 0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    io_read = 1'b0; io_write = 1'b0; io_addr = '0; io_wdata = '0;
    #3;
    check("rst_grant", 32'(grant_out), 32'(0));
    check("rst_strobes", 32'({mem_read, mem_write, cpu_ack, io_ack, timeout_err}), 32'(0));
    check("rst_addr_data", 32'({mem_addr, mem_wdata}), 32'(0));
    @(negedge clock); reset = 1'b1;

    // Single CPU read
    cyc(); cpu_read = 1'b1; cpu_addr = 16'h0010;
    cpu_q.push_back('{wr: 1'b0, addr: 16'h0010, wdata: 16'h0000});
    @(negedge clock); check("rd_latency_idle", 32'(mem_read), 32'(0));
    cyc();
    @(negedge clock);
    check("rd_strobe", 32'(mem_read), 32'(1));
    check("rd_addr", 32'(mem_addr), 32'(16'h0010));
    cyc(); dir_ack = 1'b1;
    @(negedge clock);
    check("rd_ack", 32'(cpu_ack), 32'(1));
    check("rd_data", 32'(rdata), 32'(16'hBEEF));
    cyc(); dir_ack = 1'b0; cpu_read = 1'b0;
    @(negedge clock); check("rd_then_idle", 32'(grant_out), 32'(0));

    // Simultaneous requests, last-served is now CPU
    both_test(RR);

    // Watchdog on a grant that never sees mem_ack
    to0 = to_cnt;
    cyc(); io_read = 1'b1; io_addr = 16'h0300;
    @(negedge clock);
    for (int k = 1; k <= 15; k++) begin
      cyc();
      @(negedge clock);
      check("to_pulse", 32'(timeout_err), 32'(k == 15));
    end
    check("to_io_ack", 32'(io_ack), 32'(0));
    cyc(); @(negedge clock); check("to_idle", 32'(grant_out), 32'(0));
    cyc(); @(negedge clock); check("to_regrant", 32'(grant_out), 32'(2));
    cyc(); io_read = 1'b0;
    cyc(); @(negedge clock); check("to_count", 32'(to_cnt - to0), 32'(1));

    // Withdrawal mid-grant
    to0 = to_cnt;
    cyc(); cpu_read = 1'b1; cpu_addr = 16'h0040;
    cyc(); @(negedge clock); check("wd_grant", 32'(grant_out), 32'(1));
    cyc();
    cyc(); cpu_read = 1'b0;
    @(negedge clock);
    check("wd_strobe_drop", 32'(mem_read), 32'(0));
    check("wd_still_granted", 32'(grant_out), 32'(1));
    cyc(); @(negedge clock); check("wd_idle", 32'(grant_out), 32'(0));
    check("wd_no_timeout", 32'(to_cnt - to0), 32'(0));

    // Asynchronous reset during an IO write
    cyc(); io_write = 1'b1; io_addr = 16'h0500; io_wdata = 16'h5555;
    cyc(); @(negedge clock); check("rst_mid_write", 32'(mem_write), 32'(1));
    #2 reset = 1'b0;
    #1;
    check("rst_mid_strobe", 32'(mem_write), 32'(0));
    check("rst_mid_grant", 32'(grant_out), 32'(0));
    io_write = 1'b0;
    @(negedge clock); reset = 1'b1;
    cyc(); cpu_write = 1'b1; cpu_addr = 16'h0600; cpu_wdata = 16'hCAFE;
    cpu_q.push_back('{wr: 1'b1, addr: 16'h0600, wdata: 16'hCAFE});
    @(negedge clock); check("post_rst_idle", 32'(grant_out), 32'(0));
    cyc(); @(negedge clock); check("post_rst_grant", 32'(grant_out), 32'(1));
    cyc(); dir_ack = 1'b1;
    @(negedge clock);
    cyc(); dir_ack = 1'b0; cpu_write = 1'b0;

    // Stray ack while idle
    cyc(); dir_ack = 1'b1;
    @(negedge clock);
    check("stray_acks", 32'({cpu_ack, io_ack}), 32'(0));
    check("stray_state", 32'(grant_out), 32'(0));
    cyc(); dir_ack = 1'b0;
    @(negedge clock); check("stray_after", 32'(grant_out), 32'(0));

    // Randomized contention
    to0 = to_cnt;
    agent_en = 1'b1;
    fork
      requester(1'b0, 40);
      requester(1'b1, 40);
    join
    cyc(); agent_en = 1'b0;
    cyc(); @(negedge clock);
    check("rand_cpu_drained", 32'(cpu_q.size()), 32'(0));
    check("rand_io_drained", 32'(io_q.size()), 32'(0));
    check("rand_no_timeout", 32'(to_cnt - to0), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
